// File: rtl/gb_cpu_common_pkg.sv
// gb_cpu_common_pkg: shared fetch-unit types and constants.
package gb_cpu_common_pkg;
   typedef enum logic [1:0] {FETCH, EXEC, CB_FETCH, HALTED} fetch_state_t;
   localparam logic [7:0] CB_PREFIX_OPCODE = 8'hCB;
   localparam logic [7:0] INT_BASE_DEF = 8'h40;
   localparam int INT_COUNT = 5;
endpackage

// File: rtl/gb_cpu_int_priority.sv
// gb_cpu_int_priority: lowest-set-bit encoder over pending interrupts (bit0 wins).
module gb_cpu_int_priority
   import gb_cpu_common_pkg::*;
(
   input  logic [INT_COUNT-1:0] int_pend,
   output logic [2:0]           int_idx,
   output logic [INT_COUNT-1:0] int_onehot,
   output logic                 int_any
);
   always_comb begin
      int_idx = 3'd0;
      for (int i = INT_COUNT - 1; i >= 0; i--)
         if (int_pend[i]) int_idx = 3'(i);
   end
   assign int_onehot = int_pend & (~int_pend + 5'd1);
   assign int_any = |int_pend;
endmodule

// File: rtl/gb_cpu_fetch_unit.sv
// gb_cpu_fetch_unit: opcode fetch, CB prefix, interrupt entry and HALT for the decoder.
// Optional GB_CPU_HALT_BUG_EN: HALT with ime=0 and a pending interrupt re-reads the next byte.
module gb_cpu_fetch_unit
   import gb_cpu_common_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0100,
   parameter logic [7:0]  INT_BASE = INT_BASE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mcycle_tick,
   input  logic        instr_done,
   input  logic        halt_req,
   input  logic [15:0] pc,
   output logic        pc_inc,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        ime,
   input  logic [4:0]  int_pend,
   output logic [7:0]  opcode,
   output logic        cb_prefix,
   output logic        isr_cmd,
   output logic        instr_valid,
   output logic [7:0]  int_vector,
   output logic [4:0]  int_ack,
   output logic        halted
);
   fetch_state_t state, state_nxt;
   logic [2:0] int_idx;
   logic [4:0] int_onehot;
   logic int_any, fetch_pt, halt_exit, take_isr, do_fetch, cb_fetch, halt_enter, is_cb, bug_hit, dup_fetch;
   // RESET_PC documents the regfile's reset value; the PC itself is not held here
   logic unused_reset_pc;
   assign unused_reset_pc = ^RESET_PC;

   gb_cpu_int_priority u_prio (
      .int_pend  (int_pend),
      .int_idx   (int_idx),
      .int_onehot(int_onehot),
      .int_any   (int_any)
   );

   assign fetch_pt   = mcycle_tick && (state == FETCH || (state == EXEC && instr_done && !halt_req));
   assign halt_exit  = mcycle_tick && state == HALTED && int_any;
   assign take_isr   = (fetch_pt || halt_exit) && ime && int_any;
   assign do_fetch   = (fetch_pt || halt_exit) && !take_isr;
   assign cb_fetch   = mcycle_tick && state == CB_FETCH;
   assign halt_enter = mcycle_tick && state == EXEC && instr_done && halt_req;
   assign is_cb      = mem_rdata == CB_PREFIX_OPCODE;
`ifdef GB_CPU_HALT_BUG_EN
   assign bug_hit = halt_enter && !ime && int_any;
`else
   assign bug_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= FETCH;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (take_isr || cb_fetch) state_nxt = EXEC;
      else if (do_fetch) state_nxt = is_cb ? CB_FETCH : EXEC;
      else if (halt_enter) state_nxt = bug_hit ? FETCH : HALTED;
   end

   always_comb begin
      mem_addr = pc;
      mem_rd   = do_fetch || cb_fetch;
      pc_inc   = (do_fetch && !dup_fetch) || cb_fetch;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         opcode      <= 8'h00;
         cb_prefix   <= 1'b0;
         isr_cmd     <= 1'b0;
         instr_valid <= 1'b0;
         int_vector  <= INT_BASE;
         int_ack     <= 5'd0;
         halted      <= 1'b0;
         dup_fetch   <= 1'b0;
      end else begin
         instr_valid <= take_isr || cb_fetch || (do_fetch && !is_cb);
         int_ack     <= take_isr ? int_onehot : 5'd0;
         if (take_isr) begin
            opcode     <= 8'h00;
            cb_prefix  <= 1'b0;
            isr_cmd    <= 1'b1;
            int_vector <= INT_BASE + {2'b00, int_idx, 3'b000};
         end else if (cb_fetch || (do_fetch && !is_cb)) begin
            opcode    <= mem_rdata;
            cb_prefix <= cb_fetch;
            isr_cmd   <= 1'b0;
         end
         if (halt_enter && !bug_hit) halted <= 1'b1;
         else if (halt_exit) halted <= 1'b0;
         // the suppressed increment applies to the first fetch point after HALT only
         if (bug_hit) dup_fetch <= 1'b1;
         else if (fetch_pt || halt_exit) dup_fetch <= 1'b0;
      end
endmodule

// File: tb/tb_gb_cpu_fetch_unit.sv
// tb_gb_cpu_fetch_unit: directed table-driven bench for gb_cpu_fetch_unit.
module tb_gb_cpu_fetch_unit;
   logic clk, reset, mcycle_tick, instr_done, halt_req, ime;
   logic [15:0] pc, mem_addr;
   logic pc_inc, mem_rd, cb_prefix, isr_cmd, instr_valid, halted;
   logic [7:0] mem_rdata, opcode, int_vector;
   logic [4:0] int_pend, int_ack;
   int checks = 0, errors = 0;

   typedef struct {
      logic tick, done, hreq, ime;
      logic [4:0] pend;
      logic [7:0] rd;
      logic mrd, inc;
      logic [7:0] op;
      logic cb, isr, iv;
      logic [7:0] vec;
      logic [4:0] ack;
      logic hlt;
   } vec_t;

   vec_t vt [8];

   gb_cpu_fetch_unit dut (
      .clk(clk), .reset(reset), .mcycle_tick(mcycle_tick), .instr_done(instr_done),
      .halt_req(halt_req), .pc(pc), .pc_inc(pc_inc), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .ime(ime), .int_pend(int_pend), .opcode(opcode),
      .cb_prefix(cb_prefix), .isr_cmd(isr_cmd), .instr_valid(instr_valid),
      .int_vector(int_vector), .int_ack(int_ack), .halted(halted)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_regs(input string tag, input vec_t v);
      chk({tag, " opcode"}, 16'(opcode), 16'(v.op));
      chk({tag, " cb_prefix"}, 16'(cb_prefix), 16'(v.cb));
      chk({tag, " isr_cmd"}, 16'(isr_cmd), 16'(v.isr));
      chk({tag, " instr_valid"}, 16'(instr_valid), 16'(v.iv));
      chk({tag, " int_vector"}, 16'(int_vector), 16'(v.vec));
      chk({tag, " int_ack"}, 16'(int_ack), 16'(v.ack));
      chk({tag, " halted"}, 16'(halted), 16'(v.hlt));
   endtask

   task automatic apply(input string tag, input vec_t v);
      @(negedge clk);
      mcycle_tick = v.tick; instr_done = v.done; halt_req = v.hreq;
      ime = v.ime; int_pend = v.pend; mem_rdata = v.rd;
      pc = pc + 16'h0011;
      #1;
      chk({tag, " mem_rd"}, 16'(mem_rd), 16'(v.mrd));
      chk({tag, " pc_inc"}, 16'(pc_inc), 16'(v.inc));
      chk({tag, " mem_addr"}, mem_addr, pc);
      @(posedge clk);
      #1;
      chk_regs(tag, v);
   endtask

   initial begin
      reset = 1; mcycle_tick = 0; instr_done = 0; halt_req = 0; ime = 0;
      int_pend = 0; mem_rdata = 0; pc = 16'h0100;
      //        tick done hreq ime pend   rd     mrd inc op    cb isr iv vec    ack    hlt
      vt[0] = '{1, 0, 0, 0, 5'h00, 8'h3E, 1, 1, 8'h3E, 0, 0, 1, 8'h40, 5'h00, 0};
      vt[1] = '{0, 1, 0, 1, 5'h01, 8'h11, 0, 0, 8'h3E, 0, 0, 0, 8'h40, 5'h00, 0};
      vt[2] = '{1, 0, 0, 0, 5'h00, 8'h22, 0, 0, 8'h3E, 0, 0, 0, 8'h40, 5'h00, 0};
      vt[3] = '{1, 1, 0, 0, 5'h00, 8'hCB, 1, 1, 8'h3E, 0, 0, 0, 8'h40, 5'h00, 0};
      vt[4] = '{1, 0, 0, 1, 5'h01, 8'h37, 1, 1, 8'h37, 1, 0, 1, 8'h40, 5'h00, 0};
      vt[5] = '{1, 1, 0, 1, 5'h14, 8'h99, 0, 0, 8'h00, 0, 1, 1, 8'h50, 5'h04, 0};
      vt[6] = '{0, 1, 0, 1, 5'h14, 8'h99, 0, 0, 8'h00, 0, 1, 0, 8'h50, 5'h00, 0};
      vt[7] = '{1, 1, 1, 0, 5'h00, 8'h99, 0, 0, 8'h00, 0, 1, 0, 8'h50, 5'h00, 1};
      #1;
      chk_regs("reset", '{0, 0, 0, 0, 5'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 5'h00, 0});
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), vt[i]);
      for (int i = 0; i < 10; i++)
         apply("halt_idle", '{1, 0, 0, 0, 5'h00, 8'h55, 0, 0, 8'h00, 0, 1, 0, 8'h50, 5'h00, 1});
      apply("halt_exit_fetch", '{1, 0, 0, 0, 5'h02, 8'hAF, 1, 1, 8'hAF, 0, 0, 1, 8'h50, 5'h00, 0});
      apply("halt_again", '{1, 1, 1, 0, 5'h00, 8'h55, 0, 0, 8'hAF, 0, 0, 0, 8'h50, 5'h00, 1});
      apply("halt_exit_isr", '{1, 0, 0, 1, 5'h06, 8'h55, 0, 0, 8'h00, 0, 1, 1, 8'h48, 5'h02, 0});
`ifdef GB_CPU_HALT_BUG_EN
      apply("bug_halt", '{1, 1, 1, 0, 5'h01, 8'h55, 0, 0, 8'h00, 0, 1, 0, 8'h48, 5'h00, 0});
      apply("bug_dup", '{1, 0, 0, 0, 5'h00, 8'h12, 1, 0, 8'h12, 0, 0, 1, 8'h48, 5'h00, 0});
`else
      apply("nobug_halt", '{1, 1, 1, 0, 5'h01, 8'h55, 0, 0, 8'h00, 0, 1, 0, 8'h48, 5'h00, 1});
      apply("nobug_exit", '{1, 0, 0, 0, 5'h01, 8'h12, 1, 1, 8'h12, 0, 0, 1, 8'h48, 5'h00, 0});
`endif
      apply("after_halt", '{1, 1, 0, 0, 5'h00, 8'h34, 1, 1, 8'h34, 0, 0, 1, 8'h48, 5'h00, 0});
      apply("cb1_pre", '{1, 1, 0, 0, 5'h00, 8'hCB, 1, 1, 8'h34, 0, 0, 0, 8'h48, 5'h00, 0});
      apply("cb1_op", '{1, 0, 0, 0, 5'h00, 8'h07, 1, 1, 8'h07, 1, 0, 1, 8'h48, 5'h00, 0});
      apply("cb2_pre", '{1, 1, 0, 0, 5'h00, 8'hCB, 1, 1, 8'h07, 1, 0, 0, 8'h48, 5'h00, 0});
      // asynchronous reset while waiting for the CB opcode byte
      @(negedge clk);
      mcycle_tick = 0;
      #2 reset = 1;
      #1;
      chk("async mem_rd", 16'(mem_rd), 16'h0);
      chk_regs("async", '{0, 0, 0, 0, 5'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h40, 5'h00, 0});
      @(negedge clk);
      reset = 0;
      apply("post_reset", '{1, 0, 0, 0, 5'h00, 8'h3C, 1, 1, 8'h3C, 0, 0, 1, 8'h40, 5'h00, 0});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gb_cpu_fetch_unit.md
Name: gb_cpu_fetch_unit

Overview:
- Front end that feeds the CPU instruction decoder: fetches opcode bytes at PC and handles the 0xCB prefix.
- Arbitrates interrupt entry against the next fetch and implements HALT.
- Registered outputs opcode / cb_prefix / isr_cmd drive the decoder inputs directly; instr_valid marks a new instruction for the M-cycle sequencer.
- One fetch per M-cycle tick, overlapping the final M-cycle of the previous instruction, as on the SM83.

Parameters:
- RESET_PC, 16'h0100: PC value assumed on reset; informational only, the PC lives in the regfile.
- INT_BASE, 8'h40: vector of interrupt 0; vector n = INT_BASE + 8*n.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mcycle_tick  in  1  one-clock strobe per M-cycle; all state advances only when high
- instr_done  in  1  sequencer is in the final M-cycle of the current schedule
- halt_req  in  1  current instruction is HALT (valid with instr_done)
- pc  in  16  current program counter
- pc_inc  out  1  increment PC this tick
- mem_addr  out  16  fetch address, combinationally equal to pc
- mem_rd  out  1  fetch read strobe, combinational
- mem_rdata  in  8  read data, valid in the same tick as mem_rd
- ime  in  1  interrupt master enable
- int_pend  in  5  IE & IF, bit0 = VBlank … bit4 = Joypad
- opcode  out  8  to decoder
- cb_prefix  out  1  to decoder
- isr_cmd  out  1  to decoder
- instr_valid  out  1  one-tick pulse: opcode, cb_prefix and isr_cmd were updated this tick
- int_vector  out  8  ISR target low byte; high byte is 0x00
- int_ack  out  5  one-hot pulse clearing the serviced IF bit
- halted  out  1  core is in HALT

Behaviour:
- Reset (async): state FETCH; opcode=8'h00, cb_prefix=0, isr_cmd=0, instr_valid=0, int_vector=INT_BASE, int_ack=0, halted=0.
- States: FETCH, EXEC, CB_FETCH, HALTED.
- A fetch point is a tick where state=FETCH, or state=EXEC with instr_done=1 and halt_req=0.
- At a fetch point:
  - If ime=1 and |int_pend:
    - isr_cmd=1, cb_prefix=0, opcode=8'h00, instr_valid=1; no pc_inc, no mem_rd.
    - i = lowest set bit of int_pend; int_vector=INT_BASE+8*i; int_ack[i]=1 for that tick.
    - Next state EXEC.
  - Else mem_rd=1 and pc_inc=1:
    - If mem_rdata=8'hCB: next state CB_FETCH; instr_valid=0; opcode/cb_prefix unchanged.
    - Otherwise: opcode=mem_rdata, cb_prefix=0, isr_cmd=0, instr_valid=1; next state EXEC.
- CB_FETCH, next tick:
  - mem_rd=1, pc_inc=1; opcode=mem_rdata, cb_prefix=1, instr_valid=1; next state EXEC.
  - Interrupts are never taken between the prefix byte and the CB opcode.
- EXEC with instr_done=1 and halt_req=1: next state HALTED, halted=1; no fetch that tick.
- HALTED: no mem_rd, no pc_inc. Exit on a tick with |int_pend, regardless of ime:
  - halted=0.
  - If ime=1: take the ISR exactly as at a fetch point.
  - Else: perform a normal fetch that same tick.
- Outputs change only on ticks with mcycle_tick=1. int_ack and instr_valid are single-clock pulses.
- mcycle_tick=0: state and outputs hold, except pulses, which deassert.
- Priority: bit0 is highest. Simultaneous pending bits are serviced one per ISR.
- ime and int_pend are sampled on the fetch tick only; later changes are ignored until the next fetch point.
- Reset mid-CB_FETCH or mid-HALTED returns to FETCH with cleared outputs. Partial prefix state is discarded.

Optional Feature:
- Macro GB_CPU_HALT_BUG_EN.
- Defined: if halt_req is accepted while ime=0 and |int_pend, HALT is not entered (halted stays 0). The next fetch is performed with pc_inc=0, so the byte after HALT is read twice.
- Undefined: HALT is always entered; no duplicate fetch.

Decomposition:
- gb_cpu_common_pkg: fetch_state_t enum {FETCH, EXEC, CB_FETCH, HALTED}, CB_PREFIX_OPCODE=8'hCB, INT_BASE default, INT_COUNT=5.
- Sub-module gb_cpu_int_priority: combinational 5-bit lowest-set-bit encoder producing index, one-hot and any-pending.

Test Plan:
1. Reset then tick with mem_rdata=8'h3E, ime=0 -> mem_rd=1, pc_inc=1, opcode=8'h3E, cb_prefix=0, instr_valid pulse, state EXEC.
2. Fetch 8'hCB, then 8'h37 -> first tick instr_valid=0 with pc_inc; second tick opcode=8'h37, cb_prefix=1, instr_valid=1. With int_pend=5'b00001 and ime=1 on the second tick, no ISR.
3. instr_done with ime=1, int_pend=5'b10100 -> isr_cmd=1, opcode=8'h00, int_vector=8'h50, int_ack=5'b00100, pc_inc=0, mem_rd=0.
4. HALT accepted, int_pend=0 for 10 ticks -> halted=1, no mem_rd; then int_pend=5'b00010 with ime=0 -> halted=0, normal fetch in the same tick.
5. GB_CPU_HALT_BUG_EN defined, halt_req with ime=0 and int_pend=5'b00001 -> halted stays 0; next fetch has mem_rd=1, pc_inc=0, and the following fetch pc_inc=1. With the macro undefined -> halted=1.
6. Assert reset during CB_FETCH -> all outputs at reset values immediately, before the clock edge; next tick performs a normal fetch.
